// File: rtl/mem_port_sched.sv
// Front-end scheduler for a single block RAM with a registered read port and
// an always-writing write port. Round-robin shares the RAM between two
// requesters, runs a whole-RAM fill sequencer, and parks the write port on a
// scratch address whenever no real write is scheduled.
module mem_port_sched #(
  parameter int unsigned       ADDR_W     = 13,
  parameter int unsigned       DATA_W     = 8,
  parameter logic [ADDR_W-1:0] PARK_ADDR  = {ADDR_W{1'b1}},
  parameter logic [DATA_W-1:0] FILL_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  // Fill sequencer control
  input  logic                  fill_start,
  output logic                  fill_busy,
  output logic                  fill_done,
  // Requester side
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_we,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic [1:0]            rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  // RAM side
  output logic [31:0]           mem_raddr,
  output logic [31:0]           mem_waddr,
  output logic [DATA_W-1:0]     mem_din,
  input  logic [DATA_W-1:0]     mem_dout
);

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] cnt_q, cnt_d;
  // High when requester 1 is favoured on a tie.
  logic              ptr_q, ptr_d;
  logic [1:0]        grant;

  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] din_q, din_d;

  // Two-stage response routing: stage 1 tracks the cycle the RAM sees raddr,
  // stage 2 the cycle mem_dout is valid.
  logic              v1_q, v1_d, v2_q;
  logic              id1_q, id1_d, id2_q;

  logic              gid;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // FSM next state, fill counter and round-robin grant.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    grant   = 2'b00;
    unique case (state_q)
      StIdle: begin
        if (fill_start) begin
          state_d = StFill;
        end else begin
          if (req_valid == 2'b11) begin
            grant = ptr_q ? 2'b10 : 2'b01;
          end else begin
            grant = req_valid;
          end
          // After serving requester 0 favour 1, and vice versa.
          if (grant != 2'b00) begin
            ptr_d = grant[0];
          end
        end
      end
      StFill: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == {ADDR_W{1'b1}}) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Select the granted requester's fields.
  always_comb begin
    gid       = grant[1];
    sel_we    = gid ? req_we[1] : req_we[0];
    sel_addr  = gid ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
    sel_wdata = gid ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
  end

  // Next RAM port values; the write port parks whenever nothing is written.
  always_comb begin
    waddr_d = PARK_ADDR;
    din_d   = FILL_VALUE;
    raddr_d = raddr_q;
    v1_d    = 1'b0;
    id1_d   = 1'b0;
    if (state_q == StFill) begin
      waddr_d = cnt_q;
    end else if (grant != 2'b00) begin
      if (sel_we) begin
        waddr_d = sel_addr;
        din_d   = sel_wdata;
      end else begin
        raddr_d = sel_addr;
        v1_d    = 1'b1;
        id1_d   = gid;
      end
    end
  end

  // State, counter, pointer, RAM port and response pipeline registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ptr_q   <= 1'b0;
      raddr_q <= '0;
      waddr_q <= PARK_ADDR;
      din_q   <= FILL_VALUE;
      v1_q    <= 1'b0;
      id1_q   <= 1'b0;
      v2_q    <= 1'b0;
      id2_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      raddr_q <= raddr_d;
      waddr_q <= waddr_d;
      din_q   <= din_d;
      v1_q    <= v1_d;
      id1_q   <= id1_d;
      v2_q    <= v1_q;
      id2_q   <= id1_q;
    end
  end

  // Output decode.
  always_comb begin
    fill_busy = (state_q == StFill);
    fill_done = (state_q == StDone);
    req_ready = grant;
    rsp_valid = {v2_q & id2_q, v2_q & ~id2_q};
    rsp_rdata = mem_dout;
    mem_raddr = {{(32 - ADDR_W){1'b0}}, raddr_q};
    mem_waddr = {{(32 - ADDR_W){1'b0}}, waddr_q};
    mem_din   = din_q;
  end

endmodule

// File: tb/tb_mem_port_sched.sv
// Scoreboard bench for mem_port_sched with a behavioural registered-read RAM.
module tb_mem_port_sched;

  localparam int AW = 13;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fill_start = 1'b0;
  logic [1:0]    req_valid = '0;
  logic [1:0]    req_we = '0;
  logic [2*AW-1:0] req_addr = '0;
  logic [2*DW-1:0] req_wdata = '0;
  logic          fill_busy, fill_done;
  logic [1:0]    req_ready, rsp_valid;
  logic [DW-1:0] rsp_rdata, mem_din;
  logic [DW-1:0] mem_dout;
  logic [31:0]   mem_raddr, mem_waddr;

  mem_port_sched dut (
    .clk        (clk),
    .reset      (rst_n),
    .fill_start (fill_start),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .mem_raddr  (mem_raddr),
    .mem_waddr  (mem_waddr),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout)
  );

  always #5 clk = ~clk;

  // RAM: unconditional write, registered read.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    ram[mem_waddr[AW-1:0]] <= mem_din;
    mem_dout <= ram[mem_raddr[AW-1:0]];
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          id;
    logic [7:0]  data;
    int unsigned at;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every response must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid != 2'b00) begin
      if (sb.size() == 0) begin
        check("unexpected rsp_valid", {30'd0, rsp_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("rsp_valid routing", {30'd0, rsp_valid}, (e.id == 1) ? 32'd2 : 32'd1);
        check("rsp latency cycle", e.at, cyc);
        check("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e.data});
      end
    end
  end

  // One request cycle with hand-computed expected grant and read data.
  task automatic step(input logic [1:0] v, input logic [1:0] we,
                      input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                      input logic [1:0] exp_rdy, input logic [DW-1:0] exp_data);
    exp_t e;
    @(posedge clk);
    #1;
    req_valid = v;
    req_we    = we;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
    @(negedge clk);
    check("req_ready", {30'd0, req_ready}, {30'd0, exp_rdy});
    for (int i = 0; i < 2; i++) begin
      if (exp_rdy[i] && !we[i]) begin
        e.id   = i;
        e.data = exp_data;
        e.at   = cyc + 2;
        sb.push_back(e);
      end
    end
  endtask

  task automatic wr0(input logic [AW-1:0] a, input logic [DW-1:0] d);
    step(2'b01, 2'b01, a, '0, d, '0, 2'b01, '0);
  endtask
  task automatic wr1(input logic [AW-1:0] a, input logic [DW-1:0] d);
    step(2'b10, 2'b10, '0, a, '0, d, 2'b10, '0);
  endtask
  task automatic rd0(input logic [AW-1:0] a, input logic [DW-1:0] x);
    step(2'b01, 2'b00, a, '0, '0, '0, 2'b01, x);
  endtask
  task automatic rd1(input logic [AW-1:0] a, input logic [DW-1:0] x);
    step(2'b10, 2'b00, '0, a, '0, '0, 2'b10, x);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 2'b00, '0, '0, '0, '0, 2'b00, '0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  busy_cnt, bad_rdy, seen_done, found, done_cnt, busy_after;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset: park values, no grants, no responses.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      check("reset mem_waddr", mem_waddr, 32'h1FFF);
      check("reset mem_din", {24'd0, mem_din}, 32'd0);
      check("reset req_ready", {30'd0, req_ready}, 32'd0);
      check("reset rsp_valid", {30'd0, rsp_valid}, 32'd0);
      if (i == 0) begin
        check("reset mem_raddr", mem_raddr, 32'd0);
        check("reset fill_busy", {31'd0, fill_busy}, 32'd0);
        check("reset fill_done", {31'd0, fill_done}, 32'd0);
      end
    end

    // Read-after-write on the next cycle returns the new data.
    wr0(13'h0010, 8'hA5);
    @(negedge clk);
    rd0(13'h0010, 8'hA5);
    idle(3);

    // Preload, last grant to requester 1 so a tie next favours 0.
    wr0(13'h0020, 8'h11);
    wr1(13'h0021, 8'h22);
    // Both reading continuously: grants alternate starting with 0.
    for (int k = 0; k < 6; k++) begin
      step(2'b11, 2'b00, 13'h0020, 13'h0021, '0, '0,
           (k % 2 == 0) ? 2'b01 : 2'b10, (k % 2 == 0) ? 8'h11 : 8'h22);
    end
    idle(3);

    // A single valid requester is granted every cycle.
    rd1(13'h0010, 8'hA5);
    rd1(13'h0010, 8'hA5);
    idle(3);

    // Read accepted just before fill_start completes during the fill.
    rd0(13'h0020, 8'h11);
    @(posedge clk);
    #1;
    fill_start = 1'b1;
    req_valid  = 2'b11;
    req_we     = 2'b00;
    @(negedge clk);
    check("ready on fill_start", {30'd0, req_ready}, 32'd0);
    check("busy on fill_start", {31'd0, fill_busy}, 32'd0);

    busy_cnt  = 0;
    bad_rdy   = 0;
    seen_done = 0;
    for (int n = 0; n < 9000 && seen_done == 0; n++) begin
      @(posedge clk);
      #1;
      fill_start = 1'b0;
      @(negedge clk);
      if (n == 0) check("busy first fill cycle", {31'd0, fill_busy}, 32'd1);
      if (n == 1) begin
        check("first fill waddr", mem_waddr, 32'd0);
        check("fill din", {24'd0, mem_din}, 32'd0);
      end
      if (fill_busy) busy_cnt++;
      if (req_ready != 2'b00) bad_rdy++;
      if (fill_done) begin
        seen_done = 1;
        check("busy during done", {31'd0, fill_busy}, 32'd0);
      end
    end
    check("fill_busy cycles", busy_cnt, 32'd8192);
    check("req_ready during fill", bad_rdy, 32'd0);
    check("fill_done seen", seen_done, 32'd1);
    idle(1);
    check("fill_done one cycle", {31'd0, fill_done}, 32'd0);

    // Filled contents.
    rd0(13'h0000, 8'h00);
    rd0(13'h1000, 8'h00);
    rd0(13'h1FFE, 8'h00);
    wr0(13'h07FF, 8'h77);
    wr0(13'h0900, 8'h3C);
    idle(3);

    // Second fill aborted by reset once address 0x0800 is being written.
    @(posedge clk);
    #1;
    fill_start = 1'b1;
    @(posedge clk);
    #1;
    fill_start = 1'b0;
    found = 0;
    for (int n = 0; n < 9000; n++) begin
      @(negedge clk);
      if (mem_waddr == 32'h0800) begin
        found = 1;
        break;
      end
    end
    check("fill reached 0x0800", found, 32'd1);
    rst_n = 1'b0;
    #1;
    check("busy in reset", {31'd0, fill_busy}, 32'd0);
    check("waddr in reset", mem_waddr, 32'h1FFF);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_cnt   = 0;
    busy_after = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fill_done) done_cnt++;
      if (fill_busy) busy_after++;
    end
    check("fill_done after abort", done_cnt, 32'd0);
    check("fill_busy after abort", busy_after, 32'd0);
    rd0(13'h07FF, 8'h00);
    rd0(13'h0900, 8'h3C);
    idle(4);

    check("scoreboard drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
